// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard controller for the 5-stage MIPS pipeline, placed beside the ID/EX
// forwarding logic. It handles three hazards that forwarding cannot resolve:
// load-use stalls, taken-branch flushes, and the HI/LO interlock of the
// multi-cycle mult/div unit. It also keeps a saturating count of stall cycles
// for performance debug.
module hazard_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IFID_UsesRt,
    input  logic        IFID_HiLoUse,
    input  logic        BranchTaken,
    input  logic        MD_start,
    input  logic        MD_is_div,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        MD_busy,
    output logic        MD_done,
    output logic        MD_err,
    output logic [15:0] StallCount
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    // The counter holds "cycles left minus one", so a load of N-1 gives
    // exactly N busy cycles, with MD_done on the cycle where it reads zero.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic [15:0]      r_stall_cnt;

    logic w_load_use;
    logic w_hilo_stall;
    logic w_stall;
    logic w_md_busy;
    logic w_md_done;

    // Hazard detection. $zero is never a real dependency, and rt only
    // matters when the ID instruction actually reads it.
    assign w_load_use   = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                          ((IDEX_Rt == IFID_Rs) ||
                           (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    assign w_md_busy    = (r_state == S_BUSY);
    assign w_md_done    = w_md_busy && (r_cnt == '0);
    // HI/LO is written at the end of the done cycle, so the interlock still
    // holds in that cycle. The ID instruction then reads fresh HI/LO one
    // cycle later.
    assign w_hilo_stall = w_md_busy && IFID_HiLoUse;
    // A taken branch squashes the stalled instruction anyway, so it wins.
    assign w_stall      = (w_load_use || w_hilo_stall) && !BranchTaken;

    // Pipeline control outputs: zero-latency decode of flush/stall, forced
    // to the run state while reset is asserted.
    always_comb begin
        // NOTE: every output gets a default first so that no path through
        // the if/else chain leaves one unassigned and infers a latch.
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        if (!reset) begin
            if (BranchTaken) begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end else if (w_stall) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEX_Bubble = 1'b1;
            end
        end
    end

    assign MD_busy    = w_md_busy && !reset;
    assign MD_done    = w_md_done && !reset;
    assign MD_err     = r_err;
    assign StallCount = r_stall_cnt;

    // Mult/div occupancy FSM. A start while busy is dropped and latched as
    // a sticky error. Reset aborts the operation without a done strobe.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // right-hand side sees the pre-edge value regardless of order.
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MD_start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= MD_is_div ? DIV_LOAD : MUL_LOAD;
                    end
                end
                S_BUSY: begin
                    if (MD_start) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating stall-cycle counter. Flush cycles are not stalls, so they
    // are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Directed and randomized stimulus for hazard_stall_ctrl, checked every cycle
// against a behavioural model that tracks "cycles remaining" on the mult/div
// unit, an error flag and a saturating stall total.
module tb_hazard_stall_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        IFID_UsesRt;
    logic        IFID_HiLoUse;
    logic        BranchTaken;
    logic        MD_start;
    logic        MD_is_div;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFID_Flush;
    logic        IDEX_Bubble;
    logic        MD_busy;
    logic        MD_done;
    logic        MD_err;
    logic [15:0] StallCount;

    hazard_stall_ctrl #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N),
        .CNT_W     (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt     (IDEX_Rt),
        .IFID_Rs     (IFID_Rs),
        .IFID_Rt     (IFID_Rt),
        .IFID_UsesRt (IFID_UsesRt),
        .IFID_HiLoUse(IFID_HiLoUse),
        .BranchTaken (BranchTaken),
        .MD_start    (MD_start),
        .MD_is_div   (MD_is_div),
        .PCWrite     (PCWrite),
        .IFIDWrite   (IFIDWrite),
        .IFID_Flush  (IFID_Flush),
        .IDEX_Bubble (IDEX_Bubble),
        .MD_busy     (MD_busy),
        .MD_done     (MD_done),
        .MD_err      (MD_err),
        .StallCount  (StallCount)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_left = 0;   // mult/div cycles still to run, 0 = idle
    bit m_err  = 1'b0;
    int m_sc   = 0;
    int done_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        reset        = 1'b0;
        IDEX_MemRead = 1'b0;
        IDEX_Rt      = 5'd0;
        IFID_Rs      = 5'd0;
        IFID_Rt      = 5'd0;
        IFID_UsesRt  = 1'b0;
        IFID_HiLoUse = 1'b0;
        BranchTaken  = 1'b0;
        MD_start     = 1'b0;
        MD_is_div    = 1'b0;
    endtask

    // One clock: compare outputs at the falling edge, advance the model at
    // the rising edge, then return shortly after so the caller may re-drive.
    task automatic cycle(input bit do_check);
        bit lu, hs, st, e_pc, e_ifw, e_fl, e_bub, e_busy, e_done;
        @(negedge clk);
        lu = IDEX_MemRead && (IDEX_Rt != 0) &&
             ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
        hs = (m_left > 0) && IFID_HiLoUse;
        st = (lu || hs) && !BranchTaken;
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0;
        e_busy = (m_left > 0);
        e_done = (m_left == 1);
        if (reset) begin
            e_busy = 0;
            e_done = 0;
        end else if (BranchTaken) begin
            e_fl = 1; e_bub = 1;
        end else if (st) begin
            e_pc = 0; e_ifw = 0; e_bub = 1;
        end
        if (MD_done === 1'b1) done_pulses++;
        if (do_check) begin
            check("PCWrite",     32'(PCWrite),     32'(e_pc));
            check("IFIDWrite",   32'(IFIDWrite),   32'(e_ifw));
            check("IFID_Flush",  32'(IFID_Flush),  32'(e_fl));
            check("IDEX_Bubble", 32'(IDEX_Bubble), 32'(e_bub));
            check("MD_busy",     32'(MD_busy),     32'(e_busy));
            check("MD_done",     32'(MD_done),     32'(e_done));
            check("MD_err",      32'(MD_err),      32'(m_err));
            check("StallCount",  32'(StallCount),  32'(m_sc));
        end
        @(posedge clk);
        if (reset) begin
            m_left = 0;
            m_err  = 0;
            m_sc   = 0;
        end else begin
            if (st && m_sc < 65535) m_sc++;
            if (m_left > 0) begin
                if (MD_start) m_err = 1;
                m_left--;
            end else if (MD_start) begin
                m_left = MD_is_div ? DIV_N : MUL_N;
            end
        end
        #1;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        repeat (2) cycle(1);
        reset = 1'b0;
        cycle(1);

        // Load-use on rs: single stall cycle
        IDEX_MemRead = 1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
        cycle(1);
        set_idle();
        cycle(1);
        check("lu_count", 32'(StallCount), 32'd1);
        // $zero destination and rt-only match without UsesRt: no stall
        IDEX_MemRead = 1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; cycle(1);
        IDEX_Rt = 5'd7; IFID_Rs = 5'd1; IFID_Rt = 5'd7; IFID_UsesRt = 0; cycle(1);
        IFID_UsesRt = 1; cycle(1);
        set_idle();
        cycle(1);

        // Mult with mfhi held in ID
        done_pulses = 0;
        MD_start = 1; MD_is_div = 0; cycle(1);
        set_idle(); IFID_HiLoUse = 1;
        repeat (MUL_N + 1) cycle(1);
        set_idle();
        check("mul_done_pulses", 32'(done_pulses), 32'd1);

        // Div with a second start at busy cycle 10
        done_pulses = 0;
        MD_start = 1; MD_is_div = 1; cycle(1);
        MD_start = 0;
        for (int i = 1; i <= DIV_N + 1; i++) begin
            MD_start = (i == 10);
            cycle(1);
        end
        MD_start = 0;
        check("div_err", 32'(MD_err), 32'd1);
        check("div_done_pulses", 32'(done_pulses), 32'd1);

        // Branch with load-use and hilo interlock both active
        MD_start = 1; MD_is_div = 0; cycle(1);
        MD_start = 0;
        IDEX_MemRead = 1; IDEX_Rt = 5'd9; IFID_Rs = 5'd9; IFID_HiLoUse = 1; BranchTaken = 1;
        cycle(1);
        set_idle();
        repeat (MUL_N) cycle(1);

        // Reset in busy cycle 2 of a mult
        done_pulses = 0;
        MD_start = 1; MD_is_div = 0; cycle(1);
        MD_start = 0; cycle(1);
        reset = 1; cycle(1);
        reset = 0;
        repeat (MUL_N + 2) cycle(1);
        check("rst_no_done", 32'(done_pulses), 32'd0);
        check("rst_count", 32'(StallCount), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) == 0);
            IDEX_MemRead = 1'($urandom_range(0, 1));
            IDEX_Rt      = 5'($urandom_range(0, 7));
            IFID_Rs      = 5'($urandom_range(0, 7));
            IFID_Rt      = 5'($urandom_range(0, 7));
            IFID_UsesRt  = 1'($urandom_range(0, 1));
            IFID_HiLoUse = 1'($urandom_range(0, 1));
            BranchTaken  = ($urandom_range(0, 7) == 0);
            MD_start     = ($urandom_range(0, 11) == 0);
            MD_is_div    = ($urandom_range(0, 3) == 0);
            cycle(1);
        end

        // Saturation: 70000 consecutive stall cycles
        set_idle();
        reset = 1; cycle(1);
        reset = 0;
        IDEX_MemRead = 1; IDEX_Rt = 5'd3; IFID_Rs = 5'd3;
        repeat (70000) cycle(0);
        cycle(1);
        check("sat_count", 32'(StallCount), 32'h0000FFFF);
        set_idle();
        cycle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
